// File: rtl/tpg_pkg.sv
// Shared definitions for the NoC test-pattern generator and the receive analyzer:
// FSM states, default field positions and the packet word builder.
package tpg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } tpg_state_e;

  localparam int ID_W       = 8;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 4;

  // MSB positions of each field for the default 32-bit, 16-node configuration
  localparam int SRC_POS  = DEF_WIDTH - 1;
  localparam int DST_POS  = SRC_POS - DEF_ADDR_W;
  localparam int ID_POS   = DST_POS - DEF_ADDR_W;
  localparam int DATA_POS = ID_POS - ID_W;

  // Fields must already be in range; callers truncate the result to their word width.
  function automatic logic [63:0] pack(
    input int unsigned addr_w,
    input int unsigned data_w,
    input logic [63:0] src,
    input logic [63:0] dst,
    input logic [63:0] id,
    input logic [63:0] data
  );
    pack = (src << (addr_w + 32'(ID_W) + data_w))
         | (dst << (32'(ID_W) + data_w))
         | (id << data_w)
         | data;
  endfunction

endpackage

// File: rtl/tpg_seq.sv
// Sequential traffic pattern generator: emits {src, dst, id, data} packets to one router
// port with round-robin destinations, an optional inter-packet gap and a packet budget.
module tpg_seq
  import tpg_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 15,
  parameter int GAP          = 0,
  parameter int NUM_PKTS     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             done,
  output logic [31:0]      pkt_count
);

  localparam int AW     = N_ADDR_WIDTH;
  localparam int DATA_W = WIDTH - 2 * AW - ID_W;
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [AW-1:0] SRC       = AW'(NODE);
  localparam logic [AW-1:0] FIRST_DST = AW'((NODE + 1) % N);
  localparam logic [AW-1:0] LAST_DST  = AW'(N - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP > 0) ? GAP - 1 : 0);

  tpg_state_e        state_q, state_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              xfer;

  function automatic logic [AW-1:0] step_dst(input logic [AW-1:0] d);
    if (d == LAST_DST) begin
      return {AW{1'b0}};
    end else begin
      return d + AW'(1);
    end
  endfunction

  // A node never addresses itself, so its own index is stepped over.
  function automatic logic [AW-1:0] next_dst(input logic [AW-1:0] d);
    logic [AW-1:0] t;
    t = step_dst(d);
    if (t == SRC) begin
      t = step_dst(t);
    end else begin
      t = t;
    end
    return t;
  endfunction

  assign valid_out = (state_q == SEND);
  assign done      = (state_q == DONE);
  assign pkt_count = cnt_q;
  assign xfer      = valid_out & ready_in;
  assign data_out  = WIDTH'(pack(AW, DATA_W, 64'(SRC), 64'(dst_q), 64'(id_q), 64'(data_q)));

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    dst_d   = dst_q;
    id_d    = id_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (xfer) begin
          if ((NUM_PKTS != 0) && (({1'b0, cnt_q} + 33'd1) == 33'(NUM_PKTS))) begin
            state_d = DONE;
          end else if (GAP > 0) begin
            state_d = WAIT;
            gap_d   = GAP_LOAD;
          end else if (enable) begin
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = SEND;
        end
      end
      WAIT: begin
        if (gap_q == {GW{1'b0}}) begin
          state_d = enable ? SEND : IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Packet fields only advance on an accepted beat, so a stalled word stays stable.
    if (xfer) begin
      id_d   = id_q + 8'd1;
      data_d = data_q + DATA_W'(1);
      dst_d  = next_dst(dst_q);
      cnt_d  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    end else begin
      id_d = id_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gap_q   <= {GW{1'b0}};
      dst_q   <= FIRST_DST;
      id_q    <= 8'd0;
      data_q  <= {DATA_W{1'b0}};
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      dst_q   <= dst_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tpg_seq.sv
// Bench for tpg_seq: three instances (budget of 4, gap of 3, unlimited) checked every
// cycle against a packet-index model, plus hand-computed literal words.
module tb_tpg_seq;

  localparam int NODE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en  [3];
  logic        rdy [3];
  logic [31:0] dout[3];
  logic        vld [3];
  logic        dn  [3];
  logic [31:0] pc  [3];

  always #5 clk = ~clk;

  tpg_seq #(.WIDTH(32), .N(16), .NODE(NODE), .GAP(0), .NUM_PKTS(4)) u0 (
    .clk(clk), .rst(rst_n), .enable(en[0]), .data_out(dout[0]), .valid_out(vld[0]),
    .ready_in(rdy[0]), .done(dn[0]), .pkt_count(pc[0]));
  tpg_seq #(.WIDTH(32), .N(16), .NODE(NODE), .GAP(3), .NUM_PKTS(0)) u1 (
    .clk(clk), .rst(rst_n), .enable(en[1]), .data_out(dout[1]), .valid_out(vld[1]),
    .ready_in(rdy[1]), .done(dn[1]), .pkt_count(pc[1]));
  tpg_seq #(.WIDTH(32), .N(16), .NODE(NODE), .GAP(0), .NUM_PKTS(0)) u2 (
    .clk(clk), .rst(rst_n), .enable(en[2]), .data_out(dout[2]), .valid_out(vld[2]),
    .ready_in(rdy[2]), .done(dn[2]), .pkt_count(pc[2]));

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Packet k goes to the k-th node after NODE in cyclic order, never NODE itself.
  function automatic logic [31:0] exp_word(input int k);
    int d;
    d = (NODE + 1 + (k % 15)) % 16;
    return {4'(NODE), 4'(d), 8'(k), 16'(k)};
  endfunction

  int gap_p[3] = '{0, 3, 0};
  int num_p[3] = '{4, 0, 0};
  int m_cnt[3];
  int m_gap[3];
  bit m_valid[3];
  bit m_done[3];
  logic [31:0] log0[$];
  logic [31:0] log2[$];
  int gaps1[$];
  int low_run1 = -1;

  // Compare DUT outputs with the model, then predict the state after the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_gap[i] = 0; m_valid[i] = 1'b0; m_done[i] = 1'b0;
      end
      low_run1 = -1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        check32($sformatf("word[%0d]", i), dout[i], exp_word(m_cnt[i]));
        check32($sformatf("valid[%0d]", i), {31'd0, vld[i]}, {31'd0, m_valid[i]});
        check32($sformatf("done[%0d]", i), {31'd0, dn[i]}, {31'd0, m_done[i]});
        check32($sformatf("pkt_count[%0d]", i), pc[i], 32'(m_cnt[i]));
        if (vld[i] && rdy[i]) begin
          if (i == 0) log0.push_back(dout[i]);
          if (i == 2) log2.push_back(dout[i]);
        end
        if (i == 1) begin
          if (vld[1] && rdy[1]) begin
            if (low_run1 >= 0) gaps1.push_back(low_run1);
            low_run1 = 0;
          end else if (!vld[1] && low_run1 >= 0) begin
            low_run1++;
          end
        end
        if (m_done[i]) begin
          m_done[i] = 1'b1;
        end else if (m_valid[i] && rdy[i]) begin
          m_cnt[i]++;
          if (num_p[i] != 0 && m_cnt[i] == num_p[i]) begin
            m_done[i] = 1'b1; m_valid[i] = 1'b0;
          end else if (gap_p[i] > 0) begin
            m_gap[i] = gap_p[i]; m_valid[i] = 1'b0;
          end else begin
            m_valid[i] = en[i];
          end
        end else if (m_valid[i]) begin
          m_valid[i] = 1'b1;
        end else if (m_gap[i] > 0) begin
          m_gap[i]--;
          if (m_gap[i] == 0) m_valid[i] = en[i];
        end else begin
          m_valid[i] = en[i];
        end
      end
    end
  end

  int post_idx;

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; rdy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check32($sformatf("rst_word[%0d]", i), dout[i], 32'h3400_0000);
      check32($sformatf("rst_valid[%0d]", i), {31'd0, vld[i]}, 32'd0);
      check32($sformatf("rst_done[%0d]", i), {31'd0, dn[i]}, 32'd0);
      check32($sformatf("rst_count[%0d]", i), pc[i], 32'd0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) en[i] = 1'b1;

    repeat (100) @(posedge clk);
    #2 rdy[2] = 1'b0;
    repeat (5) @(posedge clk);
    #2 rdy[2] = 1'b1;
    repeat (4) @(posedge clk);
    #2 en[2] = 1'b0;
    repeat (3) @(posedge clk);
    #2 en[2] = 1'b1;

    for (int c = 0; c < 2000 && log2.size() < 258; c++) @(posedge clk);
    #2;
    checks++;
    if (log2.size() < 258) begin
      errors++;
      $display("FAIL u2_budget: got %0d packets expected at least 258", log2.size());
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end

    check32("u0_beats", 32'(log0.size()), 32'd4);
    check32("u0_beat0", log0[0], 32'h3400_0000);
    check32("u0_beat1", log0[1], 32'h3501_0001);
    check32("u0_beat2", log0[2], 32'h3602_0002);
    check32("u0_beat3", log0[3], 32'h3703_0003);
    check32("u0_done", {31'd0, dn[0]}, 32'd1);
    check32("u0_count", pc[0], 32'd4);
    check32("u2_dst10", {28'd0, log2[10][27:24]}, 32'd14);
    check32("u2_dst11", {28'd0, log2[11][27:24]}, 32'd15);
    check32("u2_dst12", {28'd0, log2[12][27:24]}, 32'd0);
    check32("u2_dst13", {28'd0, log2[13][27:24]}, 32'd1);
    check32("u2_dst14", {28'd0, log2[14][27:24]}, 32'd2);
    check32("u2_dst15", {28'd0, log2[15][27:24]}, 32'd4);
    check32("u2_pkt256", log2[255], 32'h34FF_00FF);
    check32("u2_pkt257", log2[256], 32'h3500_0100);
    check32("u2_no_done", {31'd0, dn[2]}, 32'd0);
    check32("u1_gap_seen", {31'd0, gaps1.size() >= 3}, 32'd1);
    for (int g = 0; g < 3 && g < gaps1.size(); g++)
      check32($sformatf("u1_gap%0d", g), 32'(gaps1[g]), 32'd3);
    check32("u2_valid_before_rst", {31'd0, vld[2]}, 32'd1);

    @(posedge clk); #3;
    post_idx = log2.size();
    rst_n = 1'b0;
    #1;
    check32("async_valid", {31'd0, vld[2]}, 32'd0);
    check32("async_count", pc[2], 32'd0);
    check32("async_word", dout[2], 32'h3400_0000);
    check32("async_done0", {31'd0, dn[0]}, 32'd0);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check32("restart_seen", {31'd0, log2.size() > post_idx + 1}, 32'd1);
    if (log2.size() > post_idx + 1) begin
      check32("restart_word0", log2[post_idx], 32'h3400_0000);
      check32("restart_word1", log2[post_idx + 1], 32'h3501_0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpg_seq.md
# tpg_seq

Sequential traffic pattern generator that injects test packets into the NoC at one router port. It is the upstream neighbour of the per-node receive analyzer and produces the same packed word that the analyzer decodes: source, destination, 8-bit id and data counter. Destinations rotate round-robin over every other node, with a programmable inter-packet gap and packet budget. Transfers use a valid/ready handshake with the router input.

## Interface
- WIDTH, 32, packet word width
- N, 16, number of nodes; must be ≥ 2
- N_ADDR_WIDTH, $clog2(N), router address width
- NODE, 15, index of the router this generator is attached to; drives the src field
- GAP, 0, idle cycles inserted after each accepted packet
- NUM_PKTS, 0, packets to send before stopping; 0 = unlimited
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- enable  in  1  start/continue generation
- data_out  out  WIDTH  packet word {src, dst, id, data}
- valid_out  out  1  data_out holds a packet
- ready_in  in  1  downstream accepts the word this cycle
- done  out  1  packet budget exhausted; sticky until reset
- pkt_count  out  32  number of accepted packets

## Operation
- Field layout, MSB first:
  - src = data_out[WIDTH-1 -: N_ADDR_WIDTH] = NODE
  - dst = next N_ADDR_WIDTH bits
  - id = next 8 bits
  - data = low DATA_W = WIDTH-2·N_ADDR_WIDTH-8 bits
- Transfer occurs on any cycle with valid_out & ready_in high.
- FSM states:
  - IDLE: valid_out=0. enable=1 → SEND.
  - SEND: valid_out=1. On transfer:
    - if NUM_PKTS≠0 and pkt_count+1==NUM_PKTS → DONE
    - else if GAP>0 → WAIT
    - else if enable=1 → SEND
    - else → IDLE
  - WAIT: valid_out=0. Gap counter loads GAP-1 on entry and decrements each cycle. At 0: enable=1 → SEND, enable=0 → IDLE.
  - DONE: valid_out=0, done=1. Exits only on reset.
- On each transfer:
  - id increments mod 256.
  - data increments mod 2^DATA_W.
  - pkt_count increments and saturates at 2^32-1.
  - dst advances: dst+1 mod N, skipping NODE.
- First dst after reset is (NODE+1) mod N.
- id, data and dst never change while valid_out=1 and ready_in=0.
- enable is ignored inside SEND; a presented packet is never withdrawn.
- valid_out is a registered state decode and has no combinational dependence on ready_in.

## Timing
- Reset values:
  - valid_out=0, done=0, pkt_count=0
  - data_out = {NODE, (NODE+1) mod N, 8'd0, 0}
  - state = IDLE
- enable sampled high in IDLE at edge k → valid_out=1 after edge k (visible in cycle k+1).
- With GAP=0 and enable held high, transfers are back-to-back at one packet per cycle.
- With GAP=g, valid_out is low for exactly g cycles between transfers.
- done rises the cycle after the final transfer; valid_out falls in that same cycle.
- Asserting rst mid-packet forces every output to its reset value immediately, without waiting for clk. After rst is released, generation restarts with id 0.
- data_out is registered and updates only on the edge following a transfer.

## Structure
- Shared package tpg_pkg, also used by the analyzer:
  - state enum {IDLE, SEND, WAIT, DONE}
  - field-position localparams (SRC_POS, DST_POS, ID_POS, DATA_POS)
  - pack function building the word from src/dst/id/data
- No sub-module needed. Destination rotation is a small always block in this module.

## Test plan
- WIDTH=32, N=16, NODE=3, GAP=0, NUM_PKTS=4, ready_in=1, enable=1 → four consecutive beats:
  - first word 0x34000000
  - then 0x35010001, 0x36020002, 0x37030003
  - done=1 and pkt_count=4 the next cycle
- Hold ready_in=0 for 5 cycles during SEND → valid_out stays 1 with the word unchanged. Raising ready_in produces one transfer, and the next word has id+1.
- GAP=3 → exactly 3 cycles with valid_out=0 between successive transfers.
- Destination wrap with NODE=3 → dst sequence …,14,15,0,1,2,4; dst 3 never appears.
- NUM_PKTS=0 for 257 packets → id goes 255→0 on packet 257, data=256, done stays 0.
- Drop rst while valid_out=1 with no clock edge → valid_out and pkt_count go to 0 asynchronously. After release with enable=1, the first word is again 0x34000000.
